idex_pipe_reg: RTL and testbench

- Parametrised decode-to-execute pipeline register with a built-in load-use hazard sequencer and halt latch.
- Sits between the decode stage and the execute stage of the pipelined CPU.
- Registers all decoded control and operand fields.
- Inserts a configurable number of bubbles on load-use hazards, squashes on flush, holds on downstream back-pressure, and freezes the pipeline after a halt retires into EX.

---
 rtl/idex_pipe_reg_if.sv | 36 +++
 rtl/idex_pipe_reg.sv | 129 ++++++++++++
 tb/tb_idex_pipe_reg.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/idex_pipe_reg_if.sv
// idex_pipe_reg_if: decode-side inputs and execute-side outputs of the ID/EX register.
// The slave view belongs to the register; the master view belongs to its environment.
interface idex_pipe_reg_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
);
    logic               id_valid;
    logic [DATA_W-1:0]  id_instr, id_npc, id_rdat1, id_rdat2, id_imm;
    logic [REG_W-1:0]   id_rs, id_rt, id_dst;
    logic               id_regwr, id_dren, id_dwen, id_halt;
    logic [ALUOP_W-1:0] id_aluop;
    logic [1:0]         id_alusrc;
    logic               ex_ready, flush;
    logic               ex_valid;
    logic [DATA_W-1:0]  ex_instr, ex_npc, ex_rdat1, ex_rdat2, ex_imm;
    logic [REG_W-1:0]   ex_rs, ex_rt, ex_dst;
    logic               ex_regwr, ex_dren, ex_dwen, ex_halt;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [1:0]         ex_alusrc;
    logic               id_stall, halted;

    modport slave (
        input  id_valid, id_instr, id_npc, id_rdat1, id_rdat2, id_imm, id_rs, id_rt, id_dst,
               id_regwr, id_dren, id_dwen, id_halt, id_aluop, id_alusrc, ex_ready, flush,
        output ex_valid, ex_instr, ex_npc, ex_rdat1, ex_rdat2, ex_imm, ex_rs, ex_rt, ex_dst,
               ex_regwr, ex_dren, ex_dwen, ex_halt, ex_aluop, ex_alusrc, id_stall, halted
    );

    modport master (
        output id_valid, id_instr, id_npc, id_rdat1, id_rdat2, id_imm, id_rs, id_rt, id_dst,
               id_regwr, id_dren, id_dwen, id_halt, id_aluop, id_alusrc, ex_ready, flush,
        input  ex_valid, ex_instr, ex_npc, ex_rdat1, ex_rdat2, ex_imm, ex_rs, ex_rt, ex_dst,
               ex_regwr, ex_dren, ex_dwen, ex_halt, ex_aluop, ex_alusrc, id_stall, halted
    );
endinterface

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with load-use bubble sequencer and halt latch.
// Defining IDEX_PERF_CNT_EN adds saturating perf_bubbles/perf_flushes counters.
module idex_pipe_reg #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 4,
    parameter int LU_STALL = 1
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef IDEX_PERF_CNT_EN
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_flushes,
`endif
    idex_pipe_reg_if.slave p
);
    if (LU_STALL < 1 || LU_STALL > 7) begin : g_bad_lu_stall
        $error("LU_STALL must be in 1..7");
    end

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  instr, npc, rdat1, rdat2, imm;
        logic [REG_W-1:0]   rs, rt, dst;
        logic               regwr, dren, dwen, halt;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         alusrc;
    } ex_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ex_t        ex_q, ex_d, id_pkt;
    logic       haz;

    assign id_pkt = '{valid: p.id_valid, instr: p.id_instr, npc: p.id_npc, rdat1: p.id_rdat1,
                      rdat2: p.id_rdat2, imm: p.id_imm, rs: p.id_rs, rt: p.id_rt, dst: p.id_dst,
                      regwr: p.id_regwr, dren: p.id_dren, dwen: p.id_dwen, halt: p.id_halt,
                      aluop: p.id_aluop, alusrc: p.id_alusrc};

    assign haz = p.id_valid & ex_q.valid & ex_q.dren & (ex_q.dst != '0) &
                 ((ex_q.dst == p.id_rs) | (ex_q.dst == p.id_rt));

    // A bubble is an all-zero slot, so it can never itself raise a hazard.
    always_comb begin
        ex_d    = ex_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (p.ex_ready) begin
            case (state_q)
                RUN: begin
                    if (p.flush) begin
                        ex_d = '0;
                    end else if (haz) begin
                        ex_d    = '0;
                        cnt_d   = 3'(LU_STALL - 1);
                        state_d = (LU_STALL > 1) ? STALL : RUN;
                    end else begin
                        ex_d    = id_pkt;
                        state_d = (p.id_valid & p.id_halt) ? HALT : RUN;
                    end
                end
                STALL: begin
                    ex_d    = '0;
                    cnt_d   = p.flush ? 3'd0 : cnt_q - 3'd1;
                    state_d = (p.flush || cnt_q <= 3'd1) ? RUN : STALL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign p.id_stall  = ~p.ex_ready | (state_q != RUN) | (haz & ~p.flush);
    assign p.halted    = (state_q == HALT);
    assign p.ex_valid  = ex_q.valid;
    assign p.ex_instr  = ex_q.instr;
    assign p.ex_npc    = ex_q.npc;
    assign p.ex_rdat1  = ex_q.rdat1;
    assign p.ex_rdat2  = ex_q.rdat2;
    assign p.ex_imm    = ex_q.imm;
    assign p.ex_rs     = ex_q.rs;
    assign p.ex_rt     = ex_q.rt;
    assign p.ex_dst    = ex_q.dst;
    assign p.ex_regwr  = ex_q.regwr;
    assign p.ex_dren   = ex_q.dren;
    assign p.ex_dwen   = ex_q.dwen;
    assign p.ex_halt   = ex_q.halt;
    assign p.ex_aluop  = ex_q.aluop;
    assign p.ex_alusrc = ex_q.alusrc;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_bubbles_q, perf_bubbles_d, perf_flushes_q, perf_flushes_d;
    logic        hz_bub, fl_bub;

    assign hz_bub = p.ex_ready & ~p.flush & ((state_q == RUN & haz) | (state_q == STALL));
    assign fl_bub = p.ex_ready & p.flush & (state_q != HALT);

    always_comb begin
        perf_bubbles_d = (hz_bub && perf_bubbles_q != '1) ? perf_bubbles_q + 32'd1 : perf_bubbles_q;
        perf_flushes_d = (fl_bub && perf_flushes_q != '1) ? perf_flushes_q + 32'd1 : perf_flushes_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_bubbles_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_bubbles_q <= perf_bubbles_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_flushes = perf_flushes_q;
`endif
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed checks of the ID/EX register, with LU_STALL=1 (u1) and LU_STALL=3 (u3)
// instances fed identical decode-side stimulus.
module tb_idex_pipe_reg;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   vec = 0;
    int   errs = 0;

    always #5 CLK = ~CLK;

    idex_pipe_reg_if i1 ();
    idex_pipe_reg_if i3 ();

    assign i3.id_valid  = i1.id_valid;
    assign i3.id_instr  = i1.id_instr;
    assign i3.id_npc    = i1.id_npc;
    assign i3.id_rdat1  = i1.id_rdat1;
    assign i3.id_rdat2  = i1.id_rdat2;
    assign i3.id_imm    = i1.id_imm;
    assign i3.id_rs     = i1.id_rs;
    assign i3.id_rt     = i1.id_rt;
    assign i3.id_dst    = i1.id_dst;
    assign i3.id_regwr  = i1.id_regwr;
    assign i3.id_dren   = i1.id_dren;
    assign i3.id_dwen   = i1.id_dwen;
    assign i3.id_halt   = i1.id_halt;
    assign i3.id_aluop  = i1.id_aluop;
    assign i3.id_alusrc = i1.id_alusrc;
    assign i3.ex_ready  = i1.ex_ready;
    assign i3.flush     = i1.flush;

    idex_pipe_reg #(.LU_STALL(1)) u1 (.CLK(CLK), .RST(RST), .p(i1));
    idex_pipe_reg #(.LU_STALL(3)) u3 (.CLK(CLK), .RST(RST), .p(i3));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] npc, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] dst, input logic dren,
                             input logic regwr, input logic halt);
        i1.id_valid  = v;
        i1.id_instr  = npc ^ 32'hA5A5_0000;
        i1.id_npc    = npc;
        i1.id_rdat1  = npc + 32'd1;
        i1.id_rdat2  = npc + 32'd2;
        i1.id_imm    = npc + 32'd3;
        i1.id_rs     = rs;
        i1.id_rt     = rt;
        i1.id_dst    = dst;
        i1.id_regwr  = regwr;
        i1.id_dren   = dren;
        i1.id_dwen   = 1'b0;
        i1.id_halt   = halt;
        i1.id_aluop  = npc[5:2];
        i1.id_alusrc = 2'd1;
    endtask

    task automatic rst_pulse;
        set_instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        i1.ex_ready = 1'b1;
        i1.flush    = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset;
        set_instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        i1.ex_ready = 1'b1;
        i1.flush    = 1'b0;
        RST = 1'b1;
        tick();
        vec++; if (i1.ex_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", i1.ex_valid); end
        vec++; if (i1.ex_npc !== 32'h0) begin errs++; $display("FAIL reset_npc got %h exp 0", i1.ex_npc); end
        vec++; if (i1.halted !== 1'b0) begin errs++; $display("FAIL reset_halted got %b exp 0", i1.halted); end
        vec++; if (i1.id_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", i1.id_stall); end
        RST = 1'b0;
    endtask

    task automatic test_stream;
        rst_pulse();
        for (int i = 1; i <= 4; i++) begin
            set_instr(1'b1, 32'(4 * i), 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
            #1;
            vec++; if (i1.id_stall !== 1'b0) begin errs++; $display("FAIL stream_stall[%0d] got %b exp 0", i, i1.id_stall); end
            tick();
            vec++; if (i1.ex_npc !== 32'(4 * i)) begin errs++; $display("FAIL stream_npc[%0d] got %h exp %h", i, i1.ex_npc, 32'(4 * i)); end
            vec++; if (i1.ex_valid !== 1'b1) begin errs++; $display("FAIL stream_valid[%0d] got %b exp 1", i, i1.ex_valid); end
        end
        vec++; if (i1.ex_aluop !== 4'd4) begin errs++; $display("FAIL stream_aluop got %h exp 4", i1.ex_aluop); end
        vec++; if (i1.ex_rdat2 !== 32'h12) begin errs++; $display("FAIL stream_rdat2 got %h exp 12", i1.ex_rdat2); end
    endtask

    task automatic test_lu1;
        rst_pulse();
        set_instr(1'b1, 32'h40, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        vec++; if (i1.ex_dren !== 1'b1) begin errs++; $display("FAIL lu1_lw_dren got %b exp 1", i1.ex_dren); end
        set_instr(1'b1, 32'h44, 5'd8, 5'd9, 5'd10, 1'b0, 1'b1, 1'b0);
        #1;
        vec++; if (i1.id_stall !== 1'b1) begin errs++; $display("FAIL lu1_stall got %b exp 1", i1.id_stall); end
        tick();
        vec++; if (i1.ex_valid !== 1'b0) begin errs++; $display("FAIL lu1_bubble_valid got %b exp 0", i1.ex_valid); end
        vec++; if (i1.ex_regwr !== 1'b0) begin errs++; $display("FAIL lu1_bubble_regwr got %b exp 0", i1.ex_regwr); end
        vec++; if (i1.id_stall !== 1'b0) begin errs++; $display("FAIL lu1_stall_end got %b exp 0", i1.id_stall); end
        tick();
        vec++; if (i1.ex_npc !== 32'h44 || i1.ex_valid !== 1'b1) begin errs++; $display("FAIL lu1_add npc %h valid %b exp 44/1", i1.ex_npc, i1.ex_valid); end
        rst_pulse();
        set_instr(1'b1, 32'h50, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 32'h54, 5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 1'b0);
        #1;
        vec++; if (i1.id_stall !== 1'b0) begin errs++; $display("FAIL lu1_r0_stall got %b exp 0", i1.id_stall); end
        tick();
        vec++; if (i1.ex_npc !== 32'h54 || i1.ex_valid !== 1'b1) begin errs++; $display("FAIL lu1_r0_add npc %h valid %b exp 54/1", i1.ex_npc, i1.ex_valid); end
    endtask

    task automatic test_lu3;
        rst_pulse();
        set_instr(1'b1, 32'h80, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 32'h84, 5'd3, 5'd8, 5'd10, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            vec++; if (i3.id_stall !== 1'b1) begin errs++; $display("FAIL lu3_stall[%0d] got %b exp 1", k, i3.id_stall); end
            tick();
            vec++; if (i3.ex_valid !== 1'b0) begin errs++; $display("FAIL lu3_bubble[%0d] got %b exp 0", k, i3.ex_valid); end
        end
        #1;
        vec++; if (i3.id_stall !== 1'b0) begin errs++; $display("FAIL lu3_stall_end got %b exp 0", i3.id_stall); end
        tick();
        vec++; if (i3.ex_npc !== 32'h84 || i3.ex_valid !== 1'b1) begin errs++; $display("FAIL lu3_add npc %h valid %b exp 84/1", i3.ex_npc, i3.ex_valid); end
    endtask

    task automatic test_flush;
        rst_pulse();
        set_instr(1'b1, 32'h90, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 32'h94, 5'd8, 5'd2, 5'd10, 1'b0, 1'b1, 1'b0);
        i1.flush = 1'b1;
        #1;
        vec++; if (i3.id_stall !== 1'b0) begin errs++; $display("FAIL flush_haz_stall got %b exp 0", i3.id_stall); end
        tick();
        vec++; if (i3.ex_valid !== 1'b0) begin errs++; $display("FAIL flush_haz_bubble got %b exp 0", i3.ex_valid); end
        i1.flush = 1'b0;
        #1;
        vec++; if (i3.id_stall !== 1'b0) begin errs++; $display("FAIL flush_no_stall_entry got %b exp 0", i3.id_stall); end
        tick();
        vec++; if (i3.ex_npc !== 32'h94 || i3.ex_valid !== 1'b1) begin errs++; $display("FAIL flush_haz_next npc %h valid %b exp 94/1", i3.ex_npc, i3.ex_valid); end
        rst_pulse();
        set_instr(1'b1, 32'hA0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 32'hA4, 5'd8, 5'd2, 5'd10, 1'b0, 1'b1, 1'b0);
        tick();
        #1;
        vec++; if (i3.id_stall !== 1'b1) begin errs++; $display("FAIL flush_stall_cyc2 got %b exp 1", i3.id_stall); end
        i1.flush = 1'b1;
        tick();
        i1.flush = 1'b0;
        #1;
        vec++; if (i3.id_stall !== 1'b0) begin errs++; $display("FAIL flush_stall_run got %b exp 0", i3.id_stall); end
        vec++; if (i3.ex_valid !== 1'b0) begin errs++; $display("FAIL flush_stall_bubble got %b exp 0", i3.ex_valid); end
        tick();
        vec++; if (i3.ex_npc !== 32'hA4 || i3.ex_valid !== 1'b1) begin errs++; $display("FAIL flush_stall_next npc %h valid %b exp a4/1", i3.ex_npc, i3.ex_valid); end
    endtask

    task automatic test_back_pressure;
        rst_pulse();
        set_instr(1'b1, 32'h1C, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 32'h20, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        tick();
        set_instr(1'b1, 32'h24, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0);
        i1.ex_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            vec++; if (i1.id_stall !== 1'b1) begin errs++; $display("FAIL bp_stall[%0d] got %b exp 1", k, i1.id_stall); end
            tick();
            vec++; if (i1.ex_npc !== 32'h20 || i1.ex_valid !== 1'b1) begin errs++; $display("FAIL bp_hold[%0d] npc %h valid %b exp 20/1", k, i1.ex_npc, i1.ex_valid); end
        end
        i1.ex_ready = 1'b1;
        #1;
        vec++; if (i1.id_stall !== 1'b0) begin errs++; $display("FAIL bp_resume_stall got %b exp 0", i1.id_stall); end
        tick();
        vec++; if (i1.ex_npc !== 32'h24 || i1.ex_rs !== 5'd4) begin errs++; $display("FAIL bp_resume npc %h rs %0d exp 24/4", i1.ex_npc, i1.ex_rs); end
    endtask

    task automatic test_halt;
        rst_pulse();
        set_instr(1'b1, 32'h60, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        vec++; if (i1.ex_halt !== 1'b1) begin errs++; $display("FAIL halt_ex_halt got %b exp 1", i1.ex_halt); end
        vec++; if (i1.halted !== 1'b1) begin errs++; $display("FAIL halt_halted got %b exp 1", i1.halted); end
        set_instr(1'b1, 32'h64, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
        i1.flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vec++; if (i1.id_stall !== 1'b1) begin errs++; $display("FAIL halt_stall[%0d] got %b exp 1", k, i1.id_stall); end
            tick();
            vec++; if (i1.ex_npc !== 32'h60 || i1.ex_halt !== 1'b1) begin errs++; $display("FAIL halt_hold[%0d] npc %h halt %b exp 60/1", k, i1.ex_npc, i1.ex_halt); end
        end
        i1.flush = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        vec++; if (i1.ex_halt !== 1'b0 || i1.ex_npc !== 32'h0) begin errs++; $display("FAIL async_rst_ex halt %b npc %h exp 0/0", i1.ex_halt, i1.ex_npc); end
        vec++; if (i1.halted !== 1'b0 || i1.ex_valid !== 1'b0) begin errs++; $display("FAIL async_rst_state halted %b valid %b exp 0/0", i1.halted, i1.ex_valid); end
        tick();
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_lu1();
        test_lu3();
        test_flush();
        test_back_pressure();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
